// File: rtl/gprf_sb.sv
// gprf_sb -- general-purpose register file with per-register scoreboard
//
// Purpose:
//   NREG x DAT_W register file with binary-addressed access, plus a
//   DAT_W+1 wide rmod register. Bus1 writes and long-latency writebacks
//   share one array write port. Bus1 writes have priority, so a writeback
//   is accepted only while wr_en is low. A busy bit per register marks a
//   destination that has been reserved for a pending long-latency result.
//   Reads of a busy register raise a stall request. The sticky err flag
//   records protocol violations until the next reset.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_dat         bus1 write
//   rmod_wr_en                   load rmod with {wr_dat,1'b1}
//   rd1_*/rd2_*                  combinational read ports with stall outputs
//   rmod_rd_en/rmod_rd_dat       rmod read port
//   rsv_en/rsv_addr              reserve a destination (set busy)
//   wb_valid/wb_addr/wb_dat      writeback request
//   wb_ready                     writeback accepted this cycle (= ~wr_en)
//   busy                         scoreboard bits
//   err                          sticky protocol-violation flag
//
// Configuration:
//   GPRF_BYPASS_EN  when defined, an accepted writeback is forwarded to a
//                   read port addressing the same register in the same
//                   cycle, and that port's stall is suppressed. rmod is
//                   never bypassed.

module gprf_sb #(
  parameter int DAT_W  = 11,
  parameter int NREG   = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DAT_W-1:0]  wr_dat,
  input  logic              rmod_wr_en,
  input  logic              rd1_en,
  input  logic              rd2_en,
  input  logic [ADDR_W-1:0] rd1_addr,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic [DAT_W-1:0]  rd1_dat,
  output logic [DAT_W-1:0]  rd2_dat,
  output logic              rd1_stall,
  output logic              rd2_stall,
  input  logic              rmod_rd_en,
  output logic [DAT_W:0]    rmod_rd_dat,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DAT_W-1:0]  wb_dat,
  output logic              wb_ready,
  output logic [NREG-1:0]   busy,
  output logic              err
);

  // Register count at address width plus one, so the range check also
  // works when NREG == 2**ADDR_W.
  localparam logic [ADDR_W:0] NREG_LIM = NREG[ADDR_W:0];

  logic [DAT_W-1:0] regs_q [NREG];
  logic [DAT_W-1:0] regs_d [NREG];
  logic [DAT_W:0]   rmod_q, rmod_d;
  logic [NREG-1:0]  busy_q, busy_d;
  logic             err_q, err_d;
  logic             wbAccept;

  function automatic logic inRange(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NREG_LIM);
  endfunction

  // Bus1 owns the shared write port whenever it is writing.
  assign wb_ready = ~wr_en;
  assign wbAccept = wb_valid & ~wr_en;
  assign busy     = busy_q;
  assign err      = err_q;

  // Next-state for storage, scoreboard and error flag. The writeback clears
  // busy before the reservation is applied, so a same-cycle re-reservation
  // of the register being written back leaves it busy.
  always_comb begin
    regs_d = regs_q;
    rmod_d = rmod_q;
    busy_d = busy_q;
    err_d  = err_q;

    if (rmod_wr_en) begin
      rmod_d = {wr_dat, 1'b1};
    end

    if (wr_en) begin
      if (inRange(wr_addr)) begin
        regs_d[wr_addr] = wr_dat;
        if (busy_q[wr_addr]) begin
          err_d = 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end else if (wbAccept) begin
      if (inRange(wb_addr)) begin
        regs_d[wb_addr] = wb_dat;
        busy_d[wb_addr] = 1'b0;
        if (!busy_q[wb_addr]) begin
          err_d = 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end

    if (rsv_en) begin
      if (inRange(rsv_addr)) begin
        // Re-reserving the register whose result lands this cycle is legal.
        if (busy_q[rsv_addr] && !(wbAccept && (wb_addr == rsv_addr))) begin
          err_d = 1'b1;
        end
        busy_d[rsv_addr] = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State registers; reset clears contents, scoreboard and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      rmod_q <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      rmod_q <= rmod_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  // Combinational read ports. Out-of-range or disabled reads return 0 and
  // never stall. Data is still driven while a port is stalled.
  always_comb begin
    rd1_dat   = '0;
    rd1_stall = 1'b0;
    rd2_dat   = '0;
    rd2_stall = 1'b0;
    if (rd1_en && inRange(rd1_addr)) begin
      rd1_dat   = regs_q[rd1_addr];
      rd1_stall = busy_q[rd1_addr];
    end
    if (rd2_en && inRange(rd2_addr)) begin
      rd2_dat   = regs_q[rd2_addr];
      rd2_stall = busy_q[rd2_addr];
    end
`ifdef GPRF_BYPASS_EN
    // Forward the accepted writeback; held off during reset so outputs
    // stay at 0 while rst is high.
    if (!rst && wbAccept && inRange(wb_addr)) begin
      if (rd1_en && (rd1_addr == wb_addr)) begin
        rd1_dat   = wb_dat;
        rd1_stall = 1'b0;
      end
      if (rd2_en && (rd2_addr == wb_addr)) begin
        rd2_dat   = wb_dat;
        rd2_stall = 1'b0;
      end
    end
`endif
  end

  assign rmod_rd_dat = rmod_rd_en ? rmod_q : '0;

endmodule

// File: tb/tb_gprf_sb.sv
// tb_gprf_sb -- scoreboard-style bench for gprf_sb
//
// Two instances share all stimulus: dut (NREG=8) and dutS (NREG=6, so
// address 7 is out of range there). Stimulus pushes expected values into a
// queue; a monitor on the falling edge pops and compares.

module tb_gprf_sb;

  localparam int DW = 11;
  localparam int AW = 3;

  localparam int ID_RD1  = 0;
  localparam int ID_RD2  = 1;
  localparam int ID_ST1  = 2;
  localparam int ID_ST2  = 3;
  localparam int ID_RMOD = 4;
  localparam int ID_WBR  = 5;
  localparam int ID_BUSY = 6;
  localparam int ID_ERR  = 7;
  localparam int ID_SRD1 = 8;
  localparam int ID_SERR = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, rmod_wr_en, rd1_en, rd2_en, rmod_rd_en, rsv_en, wb_valid;
  logic [AW-1:0] wr_addr, rd1_addr, rd2_addr, rsv_addr, wb_addr;
  logic [DW-1:0] wr_dat, wb_dat;

  logic [DW-1:0] rd1_dat, rd2_dat, sRd1Dat, sRd2Dat;
  logic          rd1_stall, rd2_stall, sRd1Stall, sRd2Stall;
  logic [DW:0]   rmod_rd_dat, sRmodRdDat;
  logic          wb_ready, sWbReady, err, sErr;
  logic [7:0]    busy;
  logic [5:0]    sBusy;

  int            sigQ[$];
  logic [31:0]   expQ[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            monId;
  logic [31:0]   monExp, monAct;

  always #5 clk = ~clk;

  gprf_sb #(.DAT_W(DW), .NREG(8), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_dat(wr_dat),
    .rmod_wr_en(rmod_wr_en), .rd1_en(rd1_en), .rd2_en(rd2_en),
    .rd1_addr(rd1_addr), .rd2_addr(rd2_addr), .rd1_dat(rd1_dat), .rd2_dat(rd2_dat),
    .rd1_stall(rd1_stall), .rd2_stall(rd2_stall), .rmod_rd_en(rmod_rd_en),
    .rmod_rd_dat(rmod_rd_dat), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_dat(wb_dat), .wb_ready(wb_ready),
    .busy(busy), .err(err)
  );

  gprf_sb #(.DAT_W(DW), .NREG(6), .ADDR_W(AW)) dutS (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_dat(wr_dat),
    .rmod_wr_en(rmod_wr_en), .rd1_en(rd1_en), .rd2_en(rd2_en),
    .rd1_addr(rd1_addr), .rd2_addr(rd2_addr), .rd1_dat(sRd1Dat), .rd2_dat(sRd2Dat),
    .rd1_stall(sRd1Stall), .rd2_stall(sRd2Stall), .rmod_rd_en(rmod_rd_en),
    .rmod_rd_dat(sRmodRdDat), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_dat(wb_dat), .wb_ready(sWbReady),
    .busy(sBusy), .err(sErr)
  );

  function automatic string sigName(input int id);
    case (id)
      ID_RD1:  return "rd1_dat";
      ID_RD2:  return "rd2_dat";
      ID_ST1:  return "rd1_stall";
      ID_ST2:  return "rd2_stall";
      ID_RMOD: return "rmod_rd_dat";
      ID_WBR:  return "wb_ready";
      ID_BUSY: return "busy";
      ID_ERR:  return "err";
      ID_SRD1: return "nreg6.rd1_dat";
      default: return "nreg6.err";
    endcase
  endfunction

  function automatic logic [31:0] sample(input int id);
    case (id)
      ID_RD1:  return 32'(rd1_dat);
      ID_RD2:  return 32'(rd2_dat);
      ID_ST1:  return 32'(rd1_stall);
      ID_ST2:  return 32'(rd2_stall);
      ID_RMOD: return 32'(rmod_rd_dat);
      ID_WBR:  return 32'(wb_ready);
      ID_BUSY: return 32'(busy);
      ID_ERR:  return 32'(err);
      ID_SRD1: return 32'(sRd1Dat);
      default: return 32'(sErr);
    endcase
  endfunction

  // Monitor: outputs are combinational, so every expectation queued for the
  // current cycle is compared on the falling edge.
  always @(negedge clk) begin
    while (sigQ.size() > 0) begin
      monId  = sigQ.pop_front();
      monExp = expQ.pop_front();
      monAct = sample(monId);
      vectors++;
      if (monAct !== monExp) begin
        miscompares++;
        $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                 sigName(monId), monAct, monExp, $time);
      end
    end
  end

  task automatic checkOutput(input int id, input logic [31:0] value);
    sigQ.push_back(id);
    expQ.push_back(value);
  endtask

  // Advance one cycle and clear all strobes; inputs change 1 after the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    wr_en = 0; rmod_wr_en = 0; rd1_en = 0; rd2_en = 0; rmod_rd_en = 0;
    rsv_en = 0; wb_valid = 0;
    wr_addr = 0; rd1_addr = 0; rd2_addr = 0; rsv_addr = 0; wb_addr = 0;
    wr_dat = 0; wb_dat = 0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1;
    wr_en = 0; rmod_wr_en = 0; rd1_en = 0; rd2_en = 0; rmod_rd_en = 0;
    rsv_en = 0; wb_valid = 0;
    wr_addr = 0; rd1_addr = 0; rd2_addr = 0; rsv_addr = 0; wb_addr = 0;
    wr_dat = 0; wb_dat = 0;

    // Reset: outputs 0, wb_ready follows ~wr_en; write during reset ignored
    applyStimulus();
    rd1_en = 1; rmod_rd_en = 1; wr_en = 1; wr_dat = 11'h7FF;
    checkOutput(ID_RD1, 0); checkOutput(ID_ST1, 0); checkOutput(ID_RMOD, 0);
    checkOutput(ID_BUSY, 0); checkOutput(ID_ERR, 0); checkOutput(ID_WBR, 0);
    checkOutput(ID_SRD1, 0); checkOutput(ID_SERR, 0);
    applyStimulus();
    checkOutput(ID_WBR, 1);

    // Basic write/read and rmod
    applyStimulus();
    rst = 0;
    wr_en = 1; wr_addr = 3; wr_dat = 11'h5A5; rd1_en = 1;
    checkOutput(ID_WBR, 0); checkOutput(ID_RD1, 0);
    applyStimulus();
    rmod_wr_en = 1; wr_dat = 11'h409; rd1_en = 1; rd1_addr = 3; rd2_addr = 3;
    checkOutput(ID_RD1, 32'h5A5); checkOutput(ID_RD2, 0); checkOutput(ID_WBR, 1);
    applyStimulus();
    rmod_rd_en = 1; rd2_en = 1; rd2_addr = 3;
    checkOutput(ID_RMOD, 32'h813); checkOutput(ID_RD2, 32'h5A5);

    // Scoreboard: reserve 5, stall, writeback clears
    applyStimulus();
    rsv_en = 1; rsv_addr = 5; rd1_en = 1; rd1_addr = 5;
    checkOutput(ID_BUSY, 0); checkOutput(ID_ST1, 0);
    applyStimulus();
    rd1_en = 1; rd1_addr = 5;
    checkOutput(ID_BUSY, 32'h20); checkOutput(ID_ST1, 1); checkOutput(ID_ERR, 0);
    applyStimulus();
    wb_valid = 1; wb_addr = 5; wb_dat = 11'h123; rd1_en = 1; rd1_addr = 5;
    checkOutput(ID_WBR, 1);
`ifdef GPRF_BYPASS_EN
    checkOutput(ID_ST1, 0); checkOutput(ID_RD1, 32'h123);
`else
    checkOutput(ID_ST1, 1); checkOutput(ID_RD1, 0);
`endif
    applyStimulus();
    rd1_en = 1; rd1_addr = 5;
    checkOutput(ID_BUSY, 0); checkOutput(ID_ST1, 0); checkOutput(ID_RD1, 32'h123);

    // Arbitration: bus1 write blocks the writeback for one cycle
    applyStimulus();
    rsv_en = 1; rsv_addr = 2;
    applyStimulus();
    wb_valid = 1; wb_addr = 2; wb_dat = 11'h0AB; wr_en = 1; wr_addr = 4; wr_dat = 11'h7FF;
    checkOutput(ID_WBR, 0); checkOutput(ID_BUSY, 32'h04);
    applyStimulus();
    wb_valid = 1; wb_addr = 2; wb_dat = 11'h0AB; rd1_en = 1; rd1_addr = 4;
    checkOutput(ID_WBR, 1); checkOutput(ID_RD1, 32'h7FF); checkOutput(ID_BUSY, 32'h04);
    applyStimulus();
    rd2_en = 1; rd2_addr = 2;
    checkOutput(ID_BUSY, 0); checkOutput(ID_RD2, 32'h0AB); checkOutput(ID_ERR, 0);

    // Bypass case on rd2, address 6
    applyStimulus();
    rsv_en = 1; rsv_addr = 6;
    applyStimulus();
    wb_valid = 1; wb_addr = 6; wb_dat = 11'h3C3; rd2_en = 1; rd2_addr = 6;
`ifdef GPRF_BYPASS_EN
    checkOutput(ID_RD2, 32'h3C3); checkOutput(ID_ST2, 0);
`else
    checkOutput(ID_RD2, 0); checkOutput(ID_ST2, 1);
`endif
    applyStimulus();
    rd2_en = 1; rd2_addr = 6;
    checkOutput(ID_RD2, 32'h3C3); checkOutput(ID_ST2, 0); checkOutput(ID_BUSY, 0);

    // Same-cycle accept plus re-reserve on address 0
    applyStimulus();
    rsv_en = 1; rsv_addr = 0;
    applyStimulus();
    wb_valid = 1; wb_addr = 0; wb_dat = 11'h155; rsv_en = 1; rsv_addr = 0;
    checkOutput(ID_BUSY, 32'h01);
    applyStimulus();
    rd1_en = 1; rd1_addr = 0;
    checkOutput(ID_BUSY, 32'h01); checkOutput(ID_RD1, 32'h155); checkOutput(ID_ST1, 1);

    // Mid-run reset discards the reservation; later writeback flags err
    applyStimulus();
    rst = 1; rd1_en = 1; rd1_addr = 0; rmod_rd_en = 1;
    checkOutput(ID_BUSY, 0); checkOutput(ID_RD1, 0); checkOutput(ID_ST1, 0);
    checkOutput(ID_RMOD, 0); checkOutput(ID_ERR, 0);
    applyStimulus();
    rst = 0; wb_valid = 1; wb_addr = 0; wb_dat = 11'h011;
    applyStimulus();
    rd1_en = 1; rd1_addr = 0;
    checkOutput(ID_ERR, 1); checkOutput(ID_BUSY, 0); checkOutput(ID_RD1, 32'h011);
    applyStimulus();
    checkOutput(ID_ERR, 1);
    applyStimulus();
    rst = 1;
    checkOutput(ID_ERR, 0);

    // Violation: double reservation of address 1
    applyStimulus();
    rst = 0; rsv_en = 1; rsv_addr = 1;
    applyStimulus();
    rsv_en = 1; rsv_addr = 1;
    checkOutput(ID_ERR, 0);
    applyStimulus();
    checkOutput(ID_ERR, 1); checkOutput(ID_BUSY, 32'h02);
    applyStimulus();
    rst = 1;
    checkOutput(ID_ERR, 0);

    // Violation: bus1 write to busy address 1 (write still performed)
    applyStimulus();
    rst = 0; rsv_en = 1; rsv_addr = 1;
    applyStimulus();
    wr_en = 1; wr_addr = 1; wr_dat = 11'h222;
    checkOutput(ID_ERR, 0);
    applyStimulus();
    rd1_en = 1; rd1_addr = 1;
    checkOutput(ID_ERR, 1); checkOutput(ID_RD1, 32'h222); checkOutput(ID_BUSY, 32'h02);
    checkOutput(ID_ST1, 1);
    applyStimulus();
    rst = 1;

    // Out of range on the 6-entry instance; address 7 is valid on dut
    applyStimulus();
    rst = 0; wr_en = 1; wr_addr = 7; wr_dat = 11'h0F0;
    checkOutput(ID_SERR, 0);
    applyStimulus();
    rd1_en = 1; rd1_addr = 7;
    checkOutput(ID_SERR, 1); checkOutput(ID_SRD1, 0);
    checkOutput(ID_ERR, 0); checkOutput(ID_RD1, 32'h0F0);
    applyStimulus();
    checkOutput(ID_SERR, 1);

    applyStimulus();
    applyStimulus();
    if (sigQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", sigQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
